// File: rtl/divr1r2r3.sv
// Iterative restoring divider for the ALU: r1 = r2 / r3, rem = r2 % r3,
// one quotient bit per clock, with n/z/c/v flags matching the multiplier.
module divr1r2r3 #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] rem,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] part;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
    return s ? negate(x) : x;
  endfunction

  assign neg_a = SIGNED && a_q[WIDTH-1];
  assign neg_b = SIGNED && b_q[WIDTH-1];

  // dvd shifts left each step: dividend bits leave the top, quotient bits enter the bottom
  assign shifted = {part, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  assign q_fix = sign_q ? negate(dvd)  : dvd;
  assign r_fix = sign_r ? negate(part) : part;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      r1     <= '0;
      rem    <= '0;
      n      <= 1'b0;
      z      <= 1'b0;
      c      <= 1'b0;
      v      <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      part   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= r2;
            b_q   <= r3;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          sign_q <= neg_a ^ neg_b;
          sign_r <= neg_a;
          dvd    <= magnitude(a_q, neg_a);
          dvs    <= magnitude(b_q, neg_b);
          if (b_q == '0) begin
            r1    <= '1;
            rem   <= a_q;
            n     <= 1'b1;
            z     <= 1'b0;
            c     <= 1'b1;
            v     <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (SIGNED && (a_q == MOST_NEG) && (b_q == '1)) begin
            // Quotient 2^(WIDTH-1) is unrepresentable; wrap like the hardware would
            r1    <= a_q;
            rem   <= '0;
            n     <= a_q[WIDTH-1];
            z     <= 1'b0;
            c     <= 1'b0;
            v     <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            part  <= '0;
            cnt   <= CW'(WIDTH);
            state <= CALC;
          end
        end

        CALC: begin
          if (!trial[WIDTH]) begin
            part <= trial[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            part <= shifted[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end

        FIX: begin
          r1    <= q_fix;
          rem   <= r_fix;
          n     <= q_fix[WIDTH-1];
          z     <= (q_fix == '0);
          c     <= 1'b0;
          v     <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divr1r2r3.sv
// Bench for divr1r2r3: vector table, random signed cases against a behavioural
// divide, and hand sequences for ignored start, async reset and unsigned mode.
module tb_divr1r2r3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] r2, r3;
  logic        busy, done, n, z, c, v;
  logic [31:0] r1, rem;

  logic        u_start;
  logic [31:0] u_r2, u_r3;
  logic        u_busy, u_done, u_n, u_z, u_c, u_v;
  logic [31:0] u_r1, u_rem;

  always #5 clk = ~clk;

  divr1r2r3 #(.WIDTH(32), .SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .r2(r2), .r3(r3),
    .busy(busy), .done(done), .r1(r1), .rem(rem),
    .n(n), .z(z), .c(c), .v(v)
  );

  divr1r2r3 #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(u_start), .r2(u_r2), .r3(u_r3),
    .busy(u_busy), .done(u_done), .r1(u_r1), .rem(u_rem),
    .n(u_n), .z(u_z), .c(u_c), .v(u_v)
  );

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        n, z, c, v;
    int          lat;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[11];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t t;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    t.a = a;
    t.b = b;
    t.q = sa / sb;
    t.r = sa % sb;
    t.n = t.q[31];
    t.z = (t.q == 0);
    t.c = 1'b0;
    t.v = 1'b0;
    t.lat = 35;
    return t;
  endfunction

  // Caller is at a negedge with the DUT idle. Latency is the edge index, counted
  // from the accepting edge, at which a consumer would sample done high.
  task automatic do_vec(input vec_t t, input int intr);
    vec_t e;
    int   k;
    r2 = t.a;
    r3 = t.b;
    start = 1'b1;
    exp_q.push_back(t);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      if (k + 1 == intr) begin
        r2 = 32'd9;
        r3 = 32'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    if (k >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done for %h / %h within 100 cycles", e.a, e.b);
      return;
    end
    chk("latency", k + 1, e.lat);
    chk("r1", r1, e.q);
    chk("rem", rem, e.r);
    chk("flags_nzcv", {28'd0, n, z, c, v}, {28'd0, e.n, e.z, e.c, e.v});
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    // A start during the done cycle must be dropped
    r2 = 32'd9;
    r3 = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("r1_held", r1, e.q);
    chk("rem_held", rem, e.r);
    @(negedge clk);
    chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_u(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] q, input logic [31:0] r, input logic zz);
    int k;
    u_r2 = a;
    u_r3 = b;
    u_start = 1'b1;
    @(negedge clk);
    u_start = 1'b0;
    k = 0;
    while (u_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL u_done_timeout: no done for %h / %h", a, b);
      return;
    end
    chk("u_latency", k + 1, 35);
    chk("u_r1", u_r1, q);
    chk("u_rem", u_rem, r);
    chk("u_flags_nzcv", {28'd0, u_n, u_z, u_c, u_v}, {28'd0, q[31], zz, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t t;
    logic [31:0] a, b;
    int   dones;

    tbl[0]  = '{32'd100,      32'd7,        32'h0000000E, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 35};
    tbl[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 35};
    tbl[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b1, 1'b0, 1'b0, 1'b0, 35};
    tbl[3]  = '{32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[4]  = '{32'd3,        32'd10,       32'd0,        32'd3,        1'b0, 1'b1, 1'b0, 1'b0, 35};
    tbl[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 2};
    tbl[6]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 35};
    tbl[7]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 35};
    tbl[8]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 35};
    tbl[9]  = '{32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[10] = '{32'd1000,     32'd10,       32'd100,      32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 35};

    rst_n = 1'b0;
    start = 1'b0;
    u_start = 1'b0;
    r2 = '0;
    r3 = '0;
    u_r2 = '0;
    u_r3 = '0;
    #1;
    chk("reset_ctrl", {26'd0, busy, done, n, z, c, v}, 32'd0);
    chk("reset_r1", r1, 32'd0);
    chk("reset_rem", rem, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) do_vec(tbl[i], 0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      if (i[0]) b = b >> $urandom_range(31, 16);
      if (b == 0) b = 32'd3;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
      do_vec(model(a, b), 0);
    end

    // Second start while busy must not disturb the in-flight divide
    do_vec(tbl[10], 10);

    // Asynchronous reset mid-divide abandons the operation
    r2 = 32'd1000;
    r3 = 32'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {26'd0, busy, done, n, z, c, v}, 32'd0);
    chk("midreset_r1", r1, 32'd0);
    chk("midreset_rem", rem, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("no_done_after_reset", dones, 0);
    t = model(32'd7, 32'd2);
    do_vec(t, 0);

    do_u(32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1,        1'b0);
    do_u(32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
